// File: rtl/alu_pkg.sv
// Shared ALU op encoding and RV32I field constants for the issue stage and the ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_AND  = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of one instruction into an ALU request.
// Illegal encodings collapse to NOP with zero operands and no writeback.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter bit SUPPORT_LINK = 1'b1,
  parameter bit MASK_SHAMT   = 1'b1
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output alu_req_t    req_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_rs1_field;

  assign opcode           = instr_i[6:0];
  assign f3               = instr_i[14:12];
  assign f7               = instr_i[31:25];
  assign unused_rs1_field = ^instr_i[19:15];

  always_comb begin
    req_o         = '0;
    req_o.op      = ALU_NOP;
    req_o.rd      = instr_i[11:7];
    req_o.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        req_o.op1 = rs1_data_i;
        req_o.op2 = rs2_data_i;
        case (f3)
          F3_ADD:  req_o.op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  req_o.op = ALU_SLL;
          F3_SLT:  req_o.op = ALU_SLT;
          F3_SLTU: req_o.op = ALU_SLTU;
          F3_XOR:  req_o.op = ALU_XOR;
          F3_SR:   req_o.op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   req_o.op = ALU_OR;
          default: req_o.op = ALU_AND;
        endcase
        if ((f3 == F3_SLL || f3 == F3_SR) && MASK_SHAMT)
          req_o.op2 = {27'b0, rs2_data_i[4:0]};
        if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))))
          req_o.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        req_o.op1 = rs1_data_i;
        req_o.op2 = {{20{instr_i[31]}}, instr_i[31:20]};
        case (f3)
          F3_ADD:  req_o.op = ALU_ADD;
          F3_SLT:  req_o.op = ALU_SLT;
          F3_SLTU: req_o.op = ALU_SLTU;
          F3_XOR:  req_o.op = ALU_XOR;
          F3_OR:   req_o.op = ALU_OR;
          F3_AND:  req_o.op = ALU_AND;
          F3_SLL: begin
            req_o.op      = ALU_SLL;
            req_o.op2     = {27'b0, instr_i[24:20]};
            req_o.illegal = (f7 != F7_BASE);
          end
          default: begin
            req_o.op      = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            req_o.op2     = {27'b0, instr_i[24:20]};
            req_o.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        req_o.op  = ALU_ADD;
        req_o.op2 = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        req_o.op  = ALU_ADD;
        req_o.op1 = pc_i;
        req_o.op2 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU; the jump target is resolved elsewhere.
        req_o.op      = ALU_ADD;
        req_o.op1     = pc_i;
        req_o.op2     = 32'd4;
        req_o.illegal = !SUPPORT_LINK || (opcode == OPC_JALR && f3 != 3'd0);
      end
      default: req_o.illegal = 1'b1;
    endcase
    if (req_o.illegal) begin
      req_o.op  = ALU_NOP;
      req_o.op1 = '0;
      req_o.op2 = '0;
    end
    req_o.we = !req_o.illegal && (req_o.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: one decoded ALU request held under valid/ready until execute takes it.
// 1-cycle latency, full throughput; a flush kills both the held and any same-cycle incoming request.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter bit SUPPORT_LINK = 1'b1,
  parameter bit MASK_SHAMT   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_operand_1,
  output logic [31:0] o_operand_2,
  output logic [31:0] o_operand_3,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic        o_illegal
);

  alu_req_t dec_req;
  alu_req_t req_q;
  logic     valid_q;
  logic     load;

  alu_issue_decode #(
    .SUPPORT_LINK(SUPPORT_LINK),
    .MASK_SHAMT  (MASK_SHAMT)
  ) u_decode (
    .instr_i   (i_instr),
    .pc_i      (i_pc),
    .rs1_data_i(i_rs1_data),
    .rs2_data_i(i_rs2_data),
    .req_o     (dec_req)
  );

  assign o_ready = !valid_q || i_ready;
  assign load    = i_valid && o_ready;

  // Payload only changes on a real load, so a stalled request stays bit-stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      req_q   <= dec_req;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_op    = req_q.op;
  assign o_operand_1 = req_q.op1;
  assign o_operand_2 = req_q.op2;
  assign o_operand_3 = 32'd0;
  assign o_rd        = req_q.rd;
  assign o_rd_we     = req_q.we;
  assign o_illegal   = req_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall/flush/reset handshakes, streaming.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_in, flush;
  logic [31:0] instr, pc, rs1, rs2;
  logic        o_ready, o_valid, o_rd_we, o_illegal;
  logic [3:0]  o_alu_op;
  logic [31:0] o_op1, o_op2, o_op3;
  logic [4:0]  o_rd;
  logic        nm_ready, nm_valid, nm_we, nm_illegal;
  logic [3:0]  nm_op;
  logic [31:0] nm_op1, nm_op2, nm_op3;
  logic [4:0]  nm_rd;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_flush(flush), .o_valid(o_valid), .i_ready(ready_in),
    .o_alu_op(o_alu_op), .o_operand_1(o_op1), .o_operand_2(o_op2),
    .o_operand_3(o_op3), .o_rd(o_rd), .o_rd_we(o_rd_we), .o_illegal(o_illegal)
  );

  alu_issue_stage #(.SUPPORT_LINK(1'b1), .MASK_SHAMT(1'b0)) dut_nm (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(nm_ready),
    .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_flush(flush), .o_valid(nm_valid), .i_ready(ready_in),
    .o_alu_op(nm_op), .o_operand_1(nm_op1), .o_operand_2(nm_op2),
    .o_operand_3(nm_op3), .o_rd(nm_rd), .o_rd_we(nm_we), .o_illegal(nm_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    instr = i; pc = p; rs1 = a; rs2 = b;
  endtask

  task automatic chk_req(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic we,
                         input logic ill);
    chk({tag, ".valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, ".op"}, {28'b0, o_alu_op}, {28'b0, op});
    chk({tag, ".op1"}, o_op1, a);
    chk({tag, ".op2"}, o_op2, b);
    chk({tag, ".rd"}, {27'b0, o_rd}, {27'b0, rd});
    chk({tag, ".we"}, {31'b0, o_rd_we}, {31'b0, we});
    chk({tag, ".illegal"}, {31'b0, o_illegal}, {31'b0, ill});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, ".op"}, {28'b0, o_alu_op}, 32'd0);
    chk({tag, ".op1"}, o_op1, 32'd0);
    chk({tag, ".op2"}, o_op2, 32'd0);
    chk({tag, ".op3"}, o_op3, 32'd0);
    chk({tag, ".rd"}, {27'b0, o_rd}, 32'd0);
    chk({tag, ".we"}, {31'b0, o_rd_we}, 32'd0);
    chk({tag, ".illegal"}, {31'b0, o_illegal}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk_zero("reset");
    chk("reset.ready", {31'b0, o_ready}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // addi x5, x1, -3
    valid_in = 1'b1;
    drive(32'hFFD08293, 32'h0, 32'd10, 32'd0);
    tick();
    chk_req("addi", 4'h1, 32'd10, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0);
    chk("addi.op3", o_op3, 32'd0);

    // sub x3, x1, x2
    drive(32'h402081B3, 32'h0, 32'd7, 32'd9);
    tick();
    chk_req("sub", 4'h2, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0);

    // lui x1, 0x12345
    drive(32'h123450B7, 32'h0, 32'hDEADBEEF, 32'h0);
    tick();
    chk_req("lui", 4'h1, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0);

    // sll x1, x1, x2 with an over-range shift amount
    drive(32'h002090B3, 32'h0, 32'd1, 32'h25);
    tick();
    chk_req("sll", 4'h8, 32'd1, 32'd5, 5'd1, 1'b1, 1'b0);
    chk("sll.nomask.op2", nm_op2, 32'h25);

    // Stall: auipc x2, 1 waits behind the held sll
    ready_in = 1'b0;
    drive(32'h00001117, 32'h100, 32'h0, 32'h0);
    #1;
    chk("stall.ready", {31'b0, o_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall.ready_hold", {31'b0, o_ready}, 32'd0);
      chk_req("stall.hold", 4'h8, 32'd1, 32'd5, 5'd1, 1'b1, 1'b0);
    end
    ready_in = 1'b1;
    #1;
    chk("unstall.ready", {31'b0, o_ready}, 32'd1);
    tick();
    chk_req("auipc", 4'h1, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0);

    // Flush with a held request and an incoming one
    ready_in = 1'b0; flush = 1'b1;
    drive(32'h00308093, 32'h0, 32'd1, 32'd0);
    tick();
    chk("flush.valid", {31'b0, o_valid}, 32'd0);
    chk("flush.op_kept", {28'b0, o_alu_op}, 32'd1);
    flush = 1'b0; ready_in = 1'b1;

    drive(32'h00000000, 32'h0, 32'h55, 32'h66);
    tick();
    chk_req("zero_instr", 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    // jal x1, 8
    drive(32'h008000EF, 32'h200, 32'h0, 32'h0);
    tick();
    chk_req("jal", 4'h1, 32'h200, 32'd4, 5'd1, 1'b1, 1'b0);

    // jalr x1, 0(x2) with f3=1 is not a valid JALR
    drive(32'h000110E7, 32'h200, 32'h0, 32'h0);
    tick();
    chk_req("jalr_badf3", 4'h0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);

    // add x0, x1, x2 -> no writeback
    drive(32'h00208033, 32'h0, 32'd3, 32'd4);
    tick();
    chk_req("add_x0", 4'h1, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0);

    // slli with f7=0x20 is illegal
    drive(32'h40109093, 32'h0, 32'd3, 32'd0);
    tick();
    chk_req("slli_f7", 4'h0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);

    // srai x1, x1, 3
    drive(32'h4030D093, 32'h0, 32'h80000000, 32'd0);
    tick();
    chk_req("srai", 4'hA, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0);

    // or with f7=0x20 is illegal
    drive(32'h4020E0B3, 32'h0, 32'd1, 32'd2);
    tick();
    chk_req("or_f7", 4'h0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);

    // Reset while stalled
    drive(32'h00A0C093, 32'h0, 32'hF0, 32'd0);
    tick();
    chk_req("xori", 4'h6, 32'hF0, 32'd10, 5'd1, 1'b1, 1'b0);
    ready_in = 1'b0;
    drive(32'h00208033, 32'h0, 32'd1, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk_zero("rst_stall");
    tick();
    rst = 1'b0; ready_in = 1'b1;
    tick();

    // Back-to-back addi stream
    for (int k = 0; k < 8; k++) begin
      logic [11:0] imm;
      logic [4:0]  rd;
      imm = 12'(k * 3 + 1);
      rd  = 5'(k + 1);
      drive({imm, 5'd1, 3'b000, rd, 7'b0010011}, 32'h0, 32'd100, 32'd0);
      #1;
      chk("stream.ready", {31'b0, o_ready}, 32'd1);
      tick();
      chk_req("stream", 4'h1, 32'd100, {20'b0, imm}, rd, 1'b1, 1'b0);
    end
    valid_in = 1'b0;
    tick();
    chk("drain.valid", {31'b0, o_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
